// File: rtl/vga_fill_pkg.sv
// Shared types, default geometry and helpers for the VGA rectangle fill master.
package vga_fill_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_ADDR_W   = 16;
    localparam int COLOR_W      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } fill_state_t;

    // Avalon writedata word: top byte unused, then RGB888.
    function automatic logic [31:0] pack_writedata(input logic [COLOR_W-1:0] color);
        return {8'h00, color};
    endfunction

endpackage

// File: rtl/vga_rect_clip.sv
// Clips a rectangle to the screen; 9-bit sums so x+w up to 510 never wraps.
module vga_rect_clip
    import vga_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] w,
    input  logic [7:0] h,
    output logic [8:0] x_end,
    output logic [8:0] y_end,
    output logic       empty
);

    logic [8:0] x_sum;
    logic [8:0] y_sum;

    // Exclusive end bounds clamped to the screen, plus the nothing-to-draw flag.
    always_comb begin
        x_sum = {1'b0, x} + {1'b0, w};
        y_sum = {1'b0, y} + {1'b0, h};
        x_end = (x_sum > 9'(SCREEN_W)) ? 9'(SCREEN_W) : x_sum;
        y_end = (y_sum > 9'(SCREEN_H)) ? 9'(SCREEN_H) : y_sum;
        empty = (w == 8'd0) || (h == 8'd0) ||
                ({1'b0, x} >= 9'(SCREEN_W)) || ({1'b0, y} >= 9'(SCREEN_H));
    end

endmodule

// File: rtl/vga_rect_fill_master.sv
// Avalon-MM master filling a clipped solid-colour rectangle, one write per pixel.
module vga_rect_fill_master
    import vga_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              dataclock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [7:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [23:0]       cmd_color,
    output logic              busy,
    output logic              done,
    output logic              chipselect,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    input  logic              waitrequest
);

    fill_state_t         state, state_nx;
    logic [7:0]          cur_x, cur_y, x_start;
    logic [8:0]          x_end_r, y_end_r;
    logic [ADDR_W-1:0]   row_base;
    logic [COLOR_W-1:0]  color_r;

    logic [8:0]          clip_x_end, clip_y_end;
    logic                clip_empty;
    logic                x_more, y_last;

    vga_rect_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .x     (cmd_x),
        .y     (cmd_y),
        .w     (cmd_w),
        .h     (cmd_h),
        .x_end (clip_x_end),
        .y_end (clip_y_end),
        .empty (clip_empty)
    );

    // Position tests against the latched exclusive bounds, done in 9 bits.
    assign x_more = ({1'b0, cur_x} + 9'd1) < x_end_r;
    assign y_last = ({1'b0, cur_y} + 9'd1) >= y_end_r;

    // State register.
    always_ff @(posedge dataclock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and Avalon/handshake outputs; outputs are zero outside WRITE.
    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        write      = 1'b0;
        chipselect = 1'b0;
        address    = '0;
        writedata  = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = clip_empty ? DONE : WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                write      = 1'b1;
                chipselect = 1'b1;
                address    = row_base + ADDR_W'(cur_x);
                writedata  = pack_writedata(color_r);
                if (!waitrequest && !x_more && y_last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command latch and raster scan; holds everything while the slave stalls.
    always_ff @(posedge dataclock) begin
        if (reset) begin
            cur_x    <= '0;
            cur_y    <= '0;
            x_start  <= '0;
            x_end_r  <= '0;
            y_end_r  <= '0;
            row_base <= '0;
            color_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_x    <= cmd_x;
                        cur_y    <= cmd_y;
                        x_start  <= cmd_x;
                        x_end_r  <= clip_x_end;
                        y_end_r  <= clip_y_end;
                        row_base <= ADDR_W'(cmd_y) * ADDR_W'(SCREEN_W);
                        color_r  <= cmd_color;
                    end
                end
                WRITE: begin
                    if (!waitrequest) begin
                        if (x_more) begin
                            cur_x <= cur_x + 8'd1;
                        end else begin
                            cur_x    <= x_start;
                            cur_y    <= cur_y + 8'd1;
                            row_base <= row_base + ADDR_W'(SCREEN_W);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Directed bench for vga_rect_fill_master: raster order, stalls, clipping, reset.
module tb_vga_rect_fill_master;

    logic        dataclock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = 8'd0, cmd_y = 8'd0, cmd_w = 8'd0, cmd_h = 8'd0;
    logic [23:0] cmd_color = 24'd0;
    logic        busy, done, chipselect, write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic        waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int stall_left = 0;
    logic [15:0] stall_addr = 16'd0;

    int          q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          d_cyc[$];
    int          st_addr[$];
    logic [31:0] st_data[$];

    vga_rect_fill_master dut (
        .dataclock   (dataclock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .busy        (busy),
        .done        (done),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .waitrequest (waitrequest)
    );

    initial forever #5 dataclock = ~dataclock;

    always @(posedge dataclock) cyc <= cyc + 1;

    // Slave model: optional stall on one address, records accepted writes and done pulses.
    always @(negedge dataclock) begin
        if (write && stall_left > 0 && address == stall_addr) begin
            waitrequest = 1'b1;
            stall_left  = stall_left - 1;
            st_addr.push_back(int'(address));
            st_data.push_back(writedata);
        end else begin
            waitrequest = 1'b0;
        end
        if (write && !waitrequest) begin
            q_addr.push_back(int'(address));
            q_data.push_back(writedata);
            q_cyc.push_back(cyc);
        end
        if (done) d_cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                         input logic [7:0] h, input logic [23:0] c);
        @(negedge dataclock);
        q_addr.delete(); q_data.delete(); q_cyc.delete(); d_cyc.delete();
        st_addr.delete(); st_data.delete();
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        acc = cyc + 1;
        @(negedge dataclock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge dataclock);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: done not seen within 64 cycles", name);
        end
        @(negedge dataclock);
        @(negedge dataclock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge dataclock);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write); end
        checks++; if (chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", chipselect); end
        checks++; if (address !== 16'd0) begin errors++; $display("FAIL reset_address: got %0d want 0", address); end
        checks++; if (writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata: got %h want 0", writedata); end
        reset = 1'b0;
        @(negedge dataclock);
    endtask

    task automatic test_single_pixel();
        issue(8'd0, 8'd0, 8'd1, 8'd1, 24'hFF0000);
        wait_done("single");
        checks++;
        if (q_addr.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", q_addr.size()); end
        else begin
            checks++; if (q_addr[0] != 0) begin errors++; $display("FAIL single_addr: got %0d want 0", q_addr[0]); end
            checks++; if (q_data[0] !== 32'h00FF0000) begin errors++; $display("FAIL single_data: got %h want 00ff0000", q_data[0]); end
            checks++; if (q_cyc[0] != acc) begin errors++; $display("FAIL single_latency: got %0d want %0d", q_cyc[0], acc); end
        end
        checks++;
        if (d_cyc.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", d_cyc.size()); end
        else begin
            checks++; if (d_cyc[0] != acc + 1) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", d_cyc[0], acc + 1); end
        end
    endtask

    task automatic test_rect();
        int exp_a[6] = '{810, 811, 812, 970, 971, 972};
        issue(8'd10, 8'd5, 8'd3, 8'd2, 24'h12AB34);
        // Disturb the command inputs while busy; the latched copy must be used.
        cmd_x = 8'd99; cmd_y = 8'd1; cmd_w = 8'd7; cmd_color = 24'h000001;
        wait_done("rect");
        checks++;
        if (q_addr.size() != 6) begin errors++; $display("FAIL rect_count: got %0d want 6", q_addr.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_addr[i] != exp_a[i] || q_cyc[i] != acc + i || q_data[i] !== 32'h0012AB34) begin
                    errors++;
                    $display("FAIL rect_pixel%0d: got addr %0d cyc %0d data %h want addr %0d cyc %0d data 0012ab34",
                             i, q_addr[i], q_cyc[i], q_data[i], exp_a[i], acc + i);
                end
            end
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != acc + 6) begin
            errors++; $display("FAIL rect_done: got %0d pulses first %0d want 1 at %0d",
                               d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, acc + 6);
        end
    endtask

    task automatic test_stall();
        int exp_a[6] = '{810, 811, 812, 970, 971, 972};
        int exp_c[6];
        stall_addr = 16'd811;
        stall_left = 3;
        issue(8'd10, 8'd5, 8'd3, 8'd2, 24'h445566);
        wait_done("stall");
        exp_c = '{acc, acc + 4, acc + 5, acc + 6, acc + 7, acc + 8};
        checks++;
        if (st_addr.size() != 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", st_addr.size()); end
        for (int i = 0; i < st_addr.size(); i++) begin
            checks++;
            if (st_addr[i] != 811 || st_data[i] !== 32'h00445566) begin
                errors++; $display("FAIL stall_hold%0d: got addr %0d data %h want 811 00445566", i, st_addr[i], st_data[i]);
            end
        end
        checks++;
        if (q_addr.size() != 6) begin errors++; $display("FAIL stall_count: got %0d want 6", q_addr.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_addr[i] != exp_a[i] || q_cyc[i] != exp_c[i]) begin
                    errors++; $display("FAIL stall_pixel%0d: got addr %0d cyc %0d want addr %0d cyc %0d",
                                       i, q_addr[i], q_cyc[i], exp_a[i], exp_c[i]);
                end
            end
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != acc + 9) begin
            errors++; $display("FAIL stall_done: got %0d pulses first %0d want 1 at %0d",
                               d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, acc + 9);
        end
        stall_left = 0;
    endtask

    task automatic test_clip();
        int exp_a[4] = '{19038, 19039, 19198, 19199};
        issue(8'd158, 8'd118, 8'd4, 8'd3, 24'h0000FF);
        wait_done("clip");
        checks++;
        if (q_addr.size() != 4) begin errors++; $display("FAIL clip_count: got %0d want 4", q_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_addr[i] != exp_a[i] || q_cyc[i] != acc + i) begin
                    errors++; $display("FAIL clip_pixel%0d: got addr %0d cyc %0d want addr %0d cyc %0d",
                                       i, q_addr[i], q_cyc[i], exp_a[i], acc + i);
                end
            end
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != acc + 4) begin
            errors++; $display("FAIL clip_done: got %0d pulses want 1 at %0d", d_cyc.size(), acc + 4);
        end
    endtask

    task automatic test_zero_size();
        issue(8'd5, 8'd5, 8'd0, 8'd7, 24'hABCDEF);
        wait_done("zero");
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", q_addr.size()); end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != acc) begin
            errors++; $display("FAIL zero_done: got %0d pulses first %0d want 1 at %0d",
                               d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, acc);
        end
        issue(8'd200, 8'd10, 8'd4, 8'd4, 24'hABCDEF);
        wait_done("offscreen");
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL offscreen_writes: got %0d want 0", q_addr.size()); end
        checks++; if (d_cyc.size() != 1) begin errors++; $display("FAIL offscreen_done: got %0d want 1", d_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        issue(8'd10, 8'd5, 8'd3, 8'd2, 24'h777777);
        @(negedge dataclock);
        @(negedge dataclock);
        reset = 1'b1;
        @(negedge dataclock);
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b want 0", write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
        reset = 1'b0;
        repeat (5) @(negedge dataclock);
        checks++; if (d_cyc.size() != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", d_cyc.size()); end
        checks++;
        if (q_addr.size() < 2 || q_addr[0] != 810 || q_addr[1] != 811) begin
            errors++; $display("FAIL rstmid_prefix: got %0d writes want at least 810,811", q_addr.size());
        end
        issue(8'd20, 8'd10, 8'd2, 8'd1, 24'h010203);
        wait_done("rstmid_new");
        checks++;
        if (q_addr.size() != 2 || q_addr[0] != 1620 || q_addr[1] != 1621 || q_cyc[0] != acc) begin
            errors++; $display("FAIL rstmid_restart: got %0d writes first %0d want 1620,1621 from cycle %0d",
                               q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : -1, acc);
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != acc + 2) begin
            errors++; $display("FAIL rstmid_restart_done: got %0d pulses want 1 at %0d", d_cyc.size(), acc + 2);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_rect();
        test_stall();
        test_clip();
        test_zero_size();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
